hd44780_cmd_streamer: RTL and testbench
=======================================

Name: hd44780_cmd_streamer

Overview:
- Buffered front end for hd44780_controller.
- Accepts {rs, byte} command/data entries from a host and stores them in a small FIFO.
- Issues each entry to the controller as a single strobe. It then waits for the controller's busy rise and fall before sending the next entry.
- Lets producers (text writers, init sequencers, test harnesses) enqueue bursts without watching controller timing.

Parameters:
- DEPTH_BITS, 4, log2 of FIFO depth (16 entries).
- ACK_TIMEOUT, 16, cycles to wait for i_cont_busy to rise after a strobe before flagging an error.
- GAP_CYCLES, 0, idle cycles inserted after busy falls before the next entry may be issued.

Ports:
- CLK_I  in  1  system clock (from hd44780_syscon CLK_O).
- RST_I  in  1  reset; synchronous, active-high.
- STB_I  in  1  host write strobe.
- i_rs  in  1  register select for the entry (0 = command, 1 = data).
- i_data  in  8  byte for the entry.
- ACK_O  out  1  one-cycle pulse: previous-cycle write was accepted.
- STALL_O  out  1  FIFO full; writes are rejected.
- o_empty  out  1  FIFO empty and sequencer idle.
- o_count  out  DEPTH_BITS+1  current FIFO occupancy.
- o_overflow  out  1  sticky: a write arrived while full.
- o_ack_err  out  1  sticky: busy did not rise within ACK_TIMEOUT.
- o_cont_stb  out  1  to controller STB_I.
- o_cont_rs  out  1  to controller i_rs.
- o_cont_data  out  8  to controller i_lcd_data.
- i_cont_busy  in  1  from controller busy.

Behaviour:
- Reset values, applied on the same edge RST_I is sampled high:
  - ACK_O=0, o_cont_stb=0, o_cont_rs=0, o_cont_data=0.
  - o_count=0, STALL_O=0, o_empty=1, o_overflow=0, o_ack_err=0.
  - FIFO pointers cleared; state IDLE.
- Reset mid-operation discards all queued entries and any in-flight wait. A strobe already high is deasserted at that same edge.
- Write side:
  - At an edge with STB_I=1 and STALL_O=0, the entry is pushed and o_count increments. ACK_O=1 for the following cycle.
  - STB_I=1 while STALL_O=1: the entry is dropped, ACK_O stays 0, o_overflow is set.
  - A full FIFO rejects writes even if a pop occurs in the same cycle. STALL_O is evaluated on the pre-edge count.
  - STALL_O = (o_count == 2^DEPTH_BITS).
- Pointers are DEPTH_BITS wide and wrap modulo depth. Count width is DEPTH_BITS+1.
- Push and pop in the same edge (not full): count unchanged, both take effect.
- Sequencer FSM:
  - IDLE: if FIFO non-empty and i_cont_busy=0, pop the head into o_cont_rs/o_cont_data, set o_cont_stb=1, go to STROBE.
  - STROBE: drop o_cont_stb to 0 (strobe is exactly one cycle), clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: if i_cont_busy=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT, set o_ack_err and go to IDLE.
  - WAIT_DONE: when i_cont_busy=0, go to GAP. If GAP_CYCLES=0, go directly to IDLE.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency: a write accepted at edge k, with the controller idle and the FSM in IDLE, produces o_cont_stb=1 between edges k+1 and k+2.
- o_cont_rs and o_cont_data change only on a pop and stay stable until the next pop.
- o_empty = (o_count==0) && state==IDLE.
- Controller power-up init: the controller holds busy high after reset. IDLE waits because it requires i_cont_busy=0, so no special case is needed.
- Sticky flags clear only on reset.

Decomposition:
- Shared package hd44780_pkg holds:
  - the entry width constant (9 bits: {rs, data});
  - the FSM state encodings (IDLE, STROBE, WAIT_ACK, WAIT_DONE, GAP);
  - the RS_CMD and RS_DATA constants.
- One sub-module, hd44780_sync_fifo (parameterised width and depth), with ports push, pop, din, dout, count, full and empty.
- The top level holds the FSM, the counters and the flags.

Test Plan:
1. Reset release, no writes, busy=0 -> o_empty=1, o_cont_stb never asserts, all outputs 0.
2. Single write {rs=1, 8'h6D} at edge k, busy=0 -> ACK_O high in cycle k..k+1. o_cont_stb high in k+1..k+2 with o_cont_rs=1, o_cont_data=8'h6D.
3. Burst of 3 writes (8'h28, 8'h0C, 8'h01, rs=0); controller model raises busy 1 cycle after each strobe for 20 cycles -> exactly 3 strobes, in order, each one only after busy has fallen.
4. 17 back-to-back writes with busy held high -> first 16 accepted and o_count=16. STALL_O=1 on the 17th, which is dropped, and o_overflow=1.
5. Strobe issued, busy never rises -> o_ack_err=1 exactly ACK_TIMEOUT+2 cycles after the strobe edge, FSM in IDLE, and the next entry is issued.
6. Assert RST_I during WAIT_DONE with 5 entries queued -> next cycle o_count=0, o_empty=1, and no further strobes after release.

Source files
------------

// File: rtl/hd44780_pkg.sv
// hd44780_pkg: shared entry width, RS values and sequencer states for the HD44780 front end
package hd44780_pkg;
  localparam int ENTRY_W = 9;
  localparam logic RS_CMD = 1'b0;
  localparam logic RS_DATA = 1'b1;
  typedef enum logic [2:0] {IDLE, STROBE, WAIT_ACK, WAIT_DONE, GAP} seq_state_t;
endpackage

// File: rtl/hd44780_sync_fifo.sv
// hd44780_sync_fifo: synchronous FIFO with occupancy count and wrapping pointers
module hd44780_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_BITS:0]   count,
  output logic                  full,
  output logic                  empty
);
  logic [WIDTH-1:0] mem [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (DEPTH_BITS+1)'(2**DEPTH_BITS);
  assign empty = count == '0;
  // full is taken from the pre-edge count, so a simultaneous pop never frees a slot for this push
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_BITS'(do_push);
      rd_ptr <= rd_ptr + DEPTH_BITS'(do_pop);
      count <= count + (DEPTH_BITS+1)'(do_push) - (DEPTH_BITS+1)'(do_pop);
    end
endmodule

// File: rtl/hd44780_cmd_streamer.sv
// hd44780_cmd_streamer: buffers {rs, byte} entries and issues them one strobe at a time,
// pacing on the controller's busy handshake.
module hd44780_cmd_streamer
  import hd44780_pkg::*;
#(
  parameter int DEPTH_BITS = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic                STB_I,
  input  logic                i_rs,
  input  logic [7:0]          i_data,
  output logic                ACK_O,
  output logic                STALL_O,
  output logic                o_empty,
  output logic [DEPTH_BITS:0] o_count,
  output logic                o_overflow,
  output logic                o_ack_err,
  output logic                o_cont_stb,
  output logic                o_cont_rs,
  output logic [7:0]          o_cont_data,
  input  logic                i_cont_busy
);
  seq_state_t state;
  logic [15:0] cnt;
  logic fifo_empty, pop;
  logic [ENTRY_W-1:0] head;
  // busy held high after controller power-up naturally keeps IDLE from issuing
  assign pop = state == IDLE && !fifo_empty && !i_cont_busy;
  assign o_empty = fifo_empty && state == IDLE;
  hd44780_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH_BITS(DEPTH_BITS)) u_fifo (
    .clk(CLK_I),
    .rst(RST_I),
    .push(STB_I),
    .pop(pop),
    .din({i_rs, i_data}),
    .dout(head),
    .count(o_count),
    .full(STALL_O),
    .empty(fifo_empty)
  );
  always_ff @(posedge CLK_I)
    if (RST_I) begin
      state <= IDLE;
      cnt <= '0;
      ACK_O <= 1'b0;
      o_overflow <= 1'b0;
      o_ack_err <= 1'b0;
      o_cont_stb <= 1'b0;
      o_cont_rs <= 1'b0;
      o_cont_data <= '0;
    end else begin
      ACK_O <= STB_I && !STALL_O;
      if (STB_I && STALL_O) o_overflow <= 1'b1;
      case (state)
        IDLE:
          if (pop) begin
            {o_cont_rs, o_cont_data} <= head;
            o_cont_stb <= 1'b1;
            state <= STROBE;
          end
        STROBE: begin
          o_cont_stb <= 1'b0;
          cnt <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK:
          if (i_cont_busy) state <= WAIT_DONE;
          else if (cnt == 16'(ACK_TIMEOUT)) begin
            o_ack_err <= 1'b1;
            state <= IDLE;
          end else cnt <= cnt + 16'd1;
        WAIT_DONE:
          if (!i_cont_busy) begin
            cnt <= '0;
            state <= GAP_CYCLES == 0 ? IDLE : GAP;
          end
        GAP:
          if (cnt == 16'(GAP_CYCLES - 1)) state <= IDLE;
          else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_hd44780_cmd_streamer.sv
// tb_hd44780_cmd_streamer: scenario tasks plus a queue-based model of the streamer and a
// simple controller model that raises busy one cycle after each strobe.
module tb_hd44780_cmd_streamer;
  localparam int DEPTH = 16;
  localparam int TO = 16;
  logic clk = 0, rst = 1, stb = 0, rs = 0;
  logic [7:0] data = 0;
  logic ack, stall, empty_o, ovf, aerr, cstb, crs;
  logic [4:0] count;
  logic [7:0] cdata;
  logic busy_force = 0, ctl_auto = 0, auto_busy = 0, busy;
  int checks = 0, failures = 0, m_count = 0, n_stb = 0, busy_len = 20;
  logic [8:0] exp_q[$];
  assign busy = ctl_auto ? auto_busy : busy_force;
  always #5 clk = ~clk;
  hd44780_cmd_streamer dut (
    .CLK_I(clk), .RST_I(rst), .STB_I(stb), .i_rs(rs), .i_data(data),
    .ACK_O(ack), .STALL_O(stall), .o_empty(empty_o), .o_count(count),
    .o_overflow(ovf), .o_ack_err(aerr), .o_cont_stb(cstb), .o_cont_rs(crs),
    .o_cont_data(cdata), .i_cont_busy(busy)
  );
  // strobe scoreboard and controller model share one process so busy is read before it changes
  initial begin
    logic prev, bp, r, start;
    int left;
    logic [8:0] e;
    prev = 0; start = 0; left = 0;
    forever begin
      @(posedge clk);
      bp = busy;
      r = rst;
      #1;
      if (cstb) begin
        n_stb++;
        checks += 3;
        if (prev) begin failures++; $display("FAIL stb_width: strobe high on two consecutive cycles"); end
        if (bp) begin failures++; $display("FAIL stb_busy: strobe issued with busy=%0b, required 0", bp); end
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stb_order: got %h, required no strobe (nothing queued)", {crs, cdata});
        end else begin
          e = exp_q.pop_front();
          m_count--;
          if ({crs, cdata} !== e) begin failures++; $display("FAIL stb_order: got %h, required %h", {crs, cdata}, e); end
        end
      end
      if (r) begin
        start = 0; left = 0; auto_busy = 0;
      end else if (ctl_auto) begin
        if (start) begin left = busy_len; start = 0; end
        else if (left > 0) left--;
        auto_busy = left > 0;
        if (cstb) start = 1;
      end
      prev = cstb;
    end
  end
  task automatic drive_wr(input logic r, input logic [7:0] d, output logic acc, output logic a);
    stb = 1; rs = r; data = d;
    acc = m_count < DEPTH;
    @(posedge clk); #1;
    a = ack;
    stb = 0;
    if (acc) begin exp_q.push_back({r, d}); m_count++; end
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1; stb = 0;
    @(posedge clk); #1;
    exp_q.delete(); m_count = 0;
    checks += 4;
    if (count !== 0 || stall !== 0) begin failures++; $display("FAIL rst_count: count=%0d stall=%0b, required 0/0", count, stall); end
    if (empty_o !== 1) begin failures++; $display("FAIL rst_empty: got %0b, required 1", empty_o); end
    if ({ack, cstb, crs, cdata} !== 11'd0) begin failures++; $display("FAIL rst_outs: ack/stb/rs/data=%h, required 0", {ack, cstb, crs, cdata}); end
    if ({ovf, aerr} !== 2'b00) begin failures++; $display("FAIL rst_flags: ovf/err=%b, required 00", {ovf, aerr}); end
    @(negedge clk); rst = 0;
  endtask
  task automatic drain(input int bound);
    int n;
    for (n = 0; n < bound && (exp_q.size() != 0 || empty_o !== 1); n++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || empty_o !== 1) begin failures++; $display("FAIL drain: %0d entries still queued after %0d cycles, required 0", exp_q.size(), n); end
  endtask
  task automatic test_reset();
    ctl_auto = 0; busy_force = 0;
    do_reset();
    repeat (10) @(negedge clk);
    checks += 2;
    if (empty_o !== 1 || count !== 0) begin failures++; $display("FAIL idle_empty: empty=%0b count=%0d, required 1/0", empty_o, count); end
    if (cstb !== 0) begin failures++; $display("FAIL idle_stb: got %0b, required 0", cstb); end
  endtask
  task automatic test_single();
    logic acc, a;
    ctl_auto = 0; busy_force = 0;
    do_reset();
    @(negedge clk); drive_wr(1'b1, 8'h6D, acc, a);
    checks += 5;
    if (a !== 1) begin failures++; $display("FAIL single_ack: got %0b, required 1", a); end
    if (count !== 1) begin failures++; $display("FAIL single_count: got %0d, required 1", count); end
    @(posedge clk); #1;
    if (ack !== 0) begin failures++; $display("FAIL single_ack_pulse: got %0b, required 0", ack); end
    if ({cstb, crs, cdata} !== {1'b1, 1'b1, 8'h6D}) begin failures++; $display("FAIL single_stb: stb/rs/data=%h, required 36d", {cstb, crs, cdata}); end
    @(posedge clk); #1;
    if ({cstb, crs, cdata} !== {1'b0, 1'b1, 8'h6D}) begin failures++; $display("FAIL single_hold: stb/rs/data=%h, required 16d", {cstb, crs, cdata}); end
  endtask
  task automatic test_burst();
    logic acc, a;
    logic [7:0] b [3] = '{8'h28, 8'h0C, 8'h01};
    int s0;
    ctl_auto = 1; busy_len = 20;
    do_reset();
    s0 = n_stb;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive_wr(1'b0, b[i], acc, a);
      checks++;
      if (a !== 1) begin failures++; $display("FAIL burst_ack%0d: got %0b, required 1", i, a); end
    end
    drain(300);
    repeat (30) @(negedge clk);
    checks += 2;
    if (n_stb - s0 !== 3) begin failures++; $display("FAIL burst_strobes: got %0d, required 3", n_stb - s0); end
    if (aerr !== 0) begin failures++; $display("FAIL burst_err: got %0b, required 0", aerr); end
  endtask
  task automatic test_overflow();
    logic acc, a;
    ctl_auto = 0; busy_force = 1;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); drive_wr(1'($urandom), 8'($urandom), acc, a);
      checks += 2;
      if (a !== (i < 16)) begin failures++; $display("FAIL ovf_ack%0d: got %0b, required %0b", i, a, i < 16); end
      if (stall !== (i >= 15)) begin failures++; $display("FAIL ovf_stall%0d: got %0b, required %0b", i, stall, i >= 15); end
    end
    checks += 2;
    if (count !== 16) begin failures++; $display("FAIL ovf_count: got %0d, required 16", count); end
    if (ovf !== 1) begin failures++; $display("FAIL ovf_flag: got %0b, required 1", ovf); end
    busy_len = 3; ctl_auto = 1;
    drain(1000);
    checks += 2;
    if (aerr !== 0) begin failures++; $display("FAIL ovf_drain_err: got %0b, required 0", aerr); end
    if (ovf !== 1) begin failures++; $display("FAIL ovf_sticky: got %0b, required 1", ovf); end
  endtask
  task automatic test_timeout();
    logic acc, a;
    int n;
    ctl_auto = 0; busy_force = 0;
    do_reset();
    @(negedge clk); drive_wr(1'b0, 8'h33, acc, a);
    @(negedge clk); drive_wr(1'b1, 8'h41, acc, a);
    checks += 3;
    if (cstb !== 1) begin failures++; $display("FAIL to_first_stb: got %0b, required 1", cstb); end
    for (n = 0; n < 100 && aerr !== 1; n++) begin @(posedge clk); #1; end
    if (n !== TO + 2) begin failures++; $display("FAIL to_latency: err after %0d cycles, required %0d", n, TO + 2); end
    @(posedge clk); #1;
    if (cstb !== 1) begin failures++; $display("FAIL to_next_stb: got %0b, required 1", cstb); end
  endtask
  task automatic test_reset_mid();
    logic acc, a;
    int s0;
    ctl_auto = 1; busy_len = 30;
    do_reset();
    for (int i = 0; i < 6; i++) begin @(negedge clk); drive_wr(1'($urandom), 8'($urandom), acc, a); end
    @(negedge clk);
    checks += 2;
    if (count !== 5) begin failures++; $display("FAIL mid_count: got %0d, required 5", count); end
    if (busy !== 1) begin failures++; $display("FAIL mid_busy: got %0b, required 1", busy); end
    do_reset();
    s0 = n_stb;
    repeat (40) @(negedge clk);
    checks += 2;
    if (n_stb !== s0) begin failures++; $display("FAIL mid_strobes: got %0d, required 0", n_stb - s0); end
    if (empty_o !== 1 || count !== 0) begin failures++; $display("FAIL mid_empty: empty=%0b count=%0d, required 1/0", empty_o, count); end
  endtask
  task automatic test_random();
    logic acc, a;
    logic want_ovf;
    ctl_auto = 1; busy_len = $urandom_range(1, 4);
    do_reset();
    want_ovf = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      checks += 2;
      if (count !== 5'(m_count)) begin failures++; $display("FAIL rnd_count%0d: got %0d, required %0d", i, count, m_count); end
      if (stall !== (m_count == DEPTH)) begin failures++; $display("FAIL rnd_stall%0d: got %0b, required %0b", i, stall, m_count == DEPTH); end
      if ($urandom_range(0, 2) != 0) begin
        drive_wr(1'($urandom), 8'($urandom), acc, a);
        if (!acc) want_ovf = 1;
        checks++;
        if (a !== acc) begin failures++; $display("FAIL rnd_ack%0d: got %0b, required %0b", i, a, acc); end
      end
    end
    drain(2000);
    checks += 2;
    if (ovf !== want_ovf) begin failures++; $display("FAIL rnd_ovf: got %0b, required %0b", ovf, want_ovf); end
    if (aerr !== 0) begin failures++; $display("FAIL rnd_err: got %0b, required 0", aerr); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
